// File: rtl/filter_ui_pkg.sv
// Shared types and helpers for the filter-mode push-key interface.
// Mode width, per-key repeat states and the load clamp.
package filter_ui_pkg;

  localparam int MODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } key_fsm_t;

  // Clamp a requested mode index into 0..n-1.
  function automatic logic [MODE_W-1:0] clamp_mode(
    input logic [MODE_W-1:0] v,
    input int unsigned       n
  );
    if (32'(v) > n - 1) return MODE_W'(n - 1);
    return v;
  endfunction

endpackage

// File: rtl/key_debounce_repeat.sv
// One push-key: 2-flop sync, debounce, then press/auto-repeat step pulses.
// o_step is combinational and consumed by the mode register.
module key_debounce_repeat
  import filter_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_step
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [1:0]    sync_q;
  logic          rel_q, rel_d;
  logic          prev_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  key_fsm_t      st_q, st_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= 2'b11;
      rel_q  <= 1'b1;
      prev_q <= 1'b1;
      dcnt_q <= '0;
      st_q   <= IDLE;
      rcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], i_key_n};
      rel_q  <= rel_d;
      prev_q <= rel_q;
      dcnt_q <= dcnt_d;
      st_q   <= st_d;
      rcnt_q <= rcnt_d;
    end
  end

  always_comb begin
    rel_d  = rel_q;
    dcnt_d = '0;
    if (sync_q[1] != rel_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        rel_d = ~rel_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign press = prev_q & ~rel_q;

  always_comb begin
    st_d   = st_q;
    rcnt_d = rcnt_q;
    o_step = 1'b0;
    if (rel_q) begin
      st_d   = IDLE;
      rcnt_d = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (press) begin
            o_step = 1'b1;
            st_d   = DELAY;
            rcnt_d = '0;
          end
        end
        DELAY: begin
          if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
            o_step = 1'b1;
            st_d   = REPEAT;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
            o_step = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/filter_mode_counter.sv
// Mode index register driven by up/down push-keys and a direct load.
// Load wins over steps; simultaneous up and down steps cancel.
module filter_mode_counter
  import filter_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int NUM_MODES       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_up_n,
  input  logic              i_key_down_n,
  input  logic              i_load,
  input  logic [MODE_W-1:0] i_load_value,
  output logic [MODE_W-1:0] o_hex,
  output logic              o_changed
);

  localparam logic [MODE_W-1:0] MAXM = MODE_W'(NUM_MODES - 1);

  logic              up_step, dn_step;
  logic [MODE_W-1:0] hex_q, hex_d, load_v;
  logic              chg_q, chg_d;

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_key_n(i_key_up_n),
    .o_step (up_step)
  );

  key_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dn (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_key_n(i_key_down_n),
    .o_step (dn_step)
  );

  assign load_v = clamp_mode(i_load_value, NUM_MODES);

  always_comb begin
    hex_d = hex_q;
    chg_d = 1'b0;
    if (i_load) begin
      hex_d = load_v;
      chg_d = (load_v != hex_q);
    end else if (up_step && dn_step) begin
      hex_d = hex_q;
    end else if (up_step) begin
      hex_d = (hex_q == MAXM) ? '0 : hex_q + 1'b1;
      chg_d = 1'b1;
    end else if (dn_step) begin
      hex_d = (hex_q == '0) ? MAXM : hex_q - 1'b1;
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hex_q <= '0;
      chg_q <= 1'b0;
    end else begin
      hex_q <= hex_d;
      chg_q <= chg_d;
    end
  end

  assign o_hex     = hex_q;
  assign o_changed = chg_q;

endmodule

// File: doc/filter_mode_counter.md
Name: filter_mode_counter

Overview:
- User-interface stage directly upstream of the two-digit seven-segment decoder.
- Turns two bouncy, active-low DE2-115 push-keys (up/down) into a debounced, auto-repeating mode index 0..NUM_MODES-1.
- Drives o_hex straight into the decoder's 4-bit input and pulses o_changed so the filter pipeline can reload coefficients.
- Supports a direct load of a mode index, for example from a switch bank.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised samples needed to accept a key level change (20 ms at 50 MHz).
- REPEAT_DELAY, 25000000: hold cycles after the accepted press before the first auto-repeat event.
- REPEAT_PERIOD, 10000000: cycles between later auto-repeat events while the key is held.
- NUM_MODES, 16: number of modes, legal range 2..16.

Ports:
- i_clk, input, 1: single system clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_key_up_n, input, 1: asynchronous raw key, active-low; increments the mode.
- i_key_down_n, input, 1: asynchronous raw key, active-low; decrements the mode.
- i_load, input, 1: one-cycle strobe that loads i_load_value.
- i_load_value, input, 4: mode index to load.
- o_hex, output, 4: current mode index, registered.
- o_changed, output, 1: one-cycle pulse in the same cycle o_hex takes a new value.

Behaviour:
- Clock and reset:
  - One clock, i_clk. Reset i_rst is synchronous and active-high.
  - On reset: o_hex=0, o_changed=0, synchroniser flops=1 (released), debounced state=released, counters=0, repeat FSMs=IDLE.
- Synchroniser: each key passes through a 2-flop synchroniser before any other use.
- Debounce (per key):
  - The counter increments while the synchronised level differs from the debounced state.
  - It clears to 0 whenever the two levels match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced state toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored completely.
- Press event: a one-cycle internal pulse when the debounced state goes released->pressed.
- Repeat FSM (per key), states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on the press event; emit one step. The counter loads 0.
  - DELAY: counts held cycles. At REPEAT_DELAY-1 it emits a step, moves to REPEAT and clears the counter.
  - REPEAT: emits a step every REPEAT_PERIOD cycles.
  - Any state -> IDLE the same cycle the debounced state returns to released. No step is emitted that cycle.
- Mode update, priority per cycle:
  1. i_load: o_hex = min(i_load_value, NUM_MODES-1). o_changed=1 only if the value differs from the current o_hex.
  2. Up step and down step in the same cycle: they cancel. No change, o_changed=0.
  3. Up step: o_hex = (o_hex==NUM_MODES-1) ? 0 : o_hex+1. o_changed=1.
  4. Down step: o_hex = (o_hex==0) ? NUM_MODES-1 : o_hex-1. o_changed=1.
  - Steps that lose to i_load are dropped, not queued.
- Latency from the first sampled-low cycle of a clean press to the o_hex update: 2 (sync) + DEBOUNCE_CYCLES + 1 (register) cycles. o_changed is high in that same cycle.
- Reset mid-operation: all state returns to its reset values. A key still held when reset deasserts is treated as a fresh press and produces a step after the normal latency.
- Arithmetic: all counters are wide enough for their parameter (clog2). o_hex is never outside 0..NUM_MODES-1.

Decomposition:
- Package filter_ui_pkg:
  - key_fsm_t enum {IDLE, DELAY, REPEAT}.
  - Constant MODE_W=4.
  - Function clamp_mode().
- Sub-module key_debounce_repeat:
  - Contains synchroniser, debounce and repeat FSM.
  - Ports: i_clk, i_rst, i_key_n, o_step.
  - Instantiated twice.
- The top level holds the mode register, priority logic and o_changed.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, NUM_MODES=10.)
- Reset asserted for 3 cycles, then released with keys high -> o_hex=0, o_changed=0 for 100 cycles.
- Bounce test:
  - Up key low for 3 cycles, high for 2, then low for 6 and released -> exactly one increment, o_hex=1.
  - o_changed pulses once, 7 cycles after the start of the stable-low run.
- Wrap test:
  - From o_hex=9, one up press -> o_hex=0.
  - Then one down press -> o_hex=9.
  - Each press gives a single o_changed pulse.
- Auto-repeat test: up held 60 cycles past debounce acceptance, from o_hex=0:
  - steps at +0, +20, +28, +36, +44, +52 -> o_hex=6.
  - Release -> no further change.
- Collision test:
  - Up and down keys asserted on the same cycle -> o_hex unchanged, o_changed never pulses.
  - i_load=1 with i_load_value=12 on the same cycle as an up step -> o_hex=9; the up step is lost.
- Reset mid-hold:
  - Up held, i_rst pulsed during REPEAT -> o_hex=0.
  - With the key still held, o_hex=1 appears 7 cycles after reset deasserts.
